// File: rtl/stc_fifo_pkg.sv
// Shared constants and helpers for the n_word_fifo slice: occupancy-counter
// width and the default post-reset read-data value.
package stc_fifo_pkg;

  localparam logic [31:0] RST_VAL_DFLT = 32'hDEADC0DE;

  // Count must represent 0..depth inclusive, hence one bit beyond the pointer.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DW register-array storage: one synchronous write port and one
// asynchronous read port. The array is intentionally not reset.
module fifo_mem #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/n_word_fifo.sv
// First-word-fall-through FIFO with a registered head word and count-decoded flags.
// Define N_WORD_FIFO_STICKY_ERR_EN for sticky Ovf/Unf flags cleared by ErrClr.
module n_word_fifo
  import stc_fifo_pkg::*;
#(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   DEPTH   = 4,
  parameter int unsigned   AF_LVL  = DEPTH - 1,
  parameter logic [DW-1:0] RST_VAL = DW'(RST_VAL_DFLT)
) (
  input  logic                       Clk,
  input  logic                       Rst,
`ifdef N_WORD_FIFO_STICKY_ERR_EN
  input  logic                       ErrClr,
`endif
  input  logic [DW-1:0]              WriteData,
  input  logic                       Wr,
  input  logic                       Rd,
  output logic [DW-1:0]              ReadData,
  output logic                       Ety,
  output logic                       Full,
  output logic                       AlmostFull,
  output logic [cnt_w(DEPTH)-1:0]    Count,
  output logic                       Ovf,
  output logic                       Unf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [DW-1:0] r_rdata, w_mem_rd, w_head_nxt;
  logic          w_push, w_pop, w_ovf_evt, w_unf_evt;

  assign w_push    = Wr & (~Full | Rd);
  assign w_pop     = Rd & ~Ety;
  assign w_ovf_evt = Full & Wr & ~Rd;
  assign w_unf_evt = Ety & Rd;

  fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (Clk),
    .i_we    (w_push & ~Rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (WriteData),
    .i_raddr (w_rd_ptr_nxt),
    .o_rdata (w_mem_rd)
  );

  // Head register is loaded with the word that will be oldest after this edge;
  // if that slot is being written right now, bypass the incoming data.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_pop) w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    w_head_nxt = w_mem_rd;
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = WriteData;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= RST_VAL;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      if (w_count_nxt != '0) r_rdata <= w_head_nxt;
    end
  end

  assign ReadData   = r_rdata;
  assign Count      = r_count;
  assign Ety        = (r_count == '0);
  assign Full       = (r_count == CW'(DEPTH));
  assign AlmostFull = (r_count >= CW'(AF_LVL));

`ifdef N_WORD_FIFO_STICKY_ERR_EN
  logic r_ovf, r_unf;

  // A new event outranks a concurrent clear.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt | (r_ovf & ~ErrClr);
      r_unf <= w_unf_evt | (r_unf & ~ErrClr);
    end
  end

  assign Ovf = r_ovf;
  assign Unf = r_unf;
`else
  assign Ovf = w_ovf_evt;
  assign Unf = w_unf_evt;
`endif

endmodule
